// File: rtl/ex_arbiter_if.sv
// Request, execute-unit and response signals shared between the two requesters,
// the ex unit and the result consumer.
interface ex_arbiter_if #(
   parameter int unsigned CNT_W = 16
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [6:0]       req0_operation;
   logic [6:0]       req1_operation;
   logic [31:0]      req0_rs1;
   logic [31:0]      req1_rs1;
   logic [31:0]      req0_rs2;
   logic [31:0]      req1_rs2;
   logic [11:0]      req0_imm;
   logic [11:0]      req1_imm;
   logic [2:0]       req0_funct3;
   logic [2:0]       req1_funct3;
   logic             req0_shift_ctrl;
   logic             req1_shift_ctrl;
   logic             req0_sub_ctrl;
   logic             req1_sub_ctrl;

   logic [6:0]       ex_operation;
   logic [31:0]      ex_data_rs1;
   logic [31:0]      ex_data_rs2;
   logic [11:0]      ex_imm;
   logic [2:0]       ex_funct3;
   logic             ex_shift_ctrl;
   logic             ex_sub_ctrl;
   logic [31:0]      ex_data_out;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [31:0]      rsp_data;
   logic [CNT_W-1:0] grant_cnt0;
   logic [CNT_W-1:0] grant_cnt1;

   modport slave (
      input  req_valid, req0_operation, req1_operation, req0_rs1, req1_rs1,
             req0_rs2, req1_rs2, req0_imm, req1_imm, req0_funct3, req1_funct3,
             req0_shift_ctrl, req1_shift_ctrl, req0_sub_ctrl, req1_sub_ctrl,
             ex_data_out, rsp_ready,
      output req_ready, ex_operation, ex_data_rs1, ex_data_rs2, ex_imm,
             ex_funct3, ex_shift_ctrl, ex_sub_ctrl, rsp_valid, rsp_id,
             rsp_data, grant_cnt0, grant_cnt1
   );

   modport master (
      output req_valid, req0_operation, req1_operation, req0_rs1, req1_rs1,
             req0_rs2, req1_rs2, req0_imm, req1_imm, req0_funct3, req1_funct3,
             req0_shift_ctrl, req1_shift_ctrl, req0_sub_ctrl, req1_sub_ctrl,
             ex_data_out, rsp_ready,
      input  req_ready, ex_operation, ex_data_rs1, ex_data_rs2, ex_imm,
             ex_funct3, ex_shift_ctrl, ex_sub_ctrl, rsp_valid, rsp_id,
             rsp_data, grant_cnt0, grant_cnt1
   );
endinterface

// File: rtl/ex_arbiter.sv
// Two-way round-robin arbiter in front of the single-cycle ex unit, with a
// one-entry tagged response buffer and per-requester grant counters.
module ex_arbiter #(
   parameter int unsigned CNT_W = 16
) (
   input logic          clk,
   input logic          rst,
   ex_arbiter_if.slave  bus
);
   logic             last_q, last_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic grant_vld_c;
   logic grant_id_c;
   logic slot_free_c;
   logic xfer_c;

   // Grant: a lone requester wins; on contention the one not served last wins.
   always_comb begin
      grant_vld_c = 1'b0;
      grant_id_c  = 1'b0;
      case (bus.req_valid)
         2'b01:   begin grant_vld_c = 1'b1; grant_id_c = 1'b0;    end
         2'b10:   begin grant_vld_c = 1'b1; grant_id_c = 1'b1;    end
         2'b11:   begin grant_vld_c = 1'b1; grant_id_c = ~last_q; end
         default: begin grant_vld_c = 1'b0; grant_id_c = 1'b0;    end
      endcase
      slot_free_c = ~rsp_valid_q | bus.rsp_ready;
      xfer_c      = grant_vld_c & slot_free_c;
   end

   assign bus.req_ready = xfer_c ? (grant_id_c ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      bus.ex_operation  = 7'd0;
      bus.ex_data_rs1   = 32'd0;
      bus.ex_data_rs2   = 32'd0;
      bus.ex_imm        = 12'd0;
      bus.ex_funct3     = 3'd0;
      bus.ex_shift_ctrl = 1'b0;
      bus.ex_sub_ctrl   = 1'b0;
      if (grant_vld_c) begin
         if (grant_id_c) begin
            bus.ex_operation  = bus.req1_operation;
            bus.ex_data_rs1   = bus.req1_rs1;
            bus.ex_data_rs2   = bus.req1_rs2;
            bus.ex_imm        = bus.req1_imm;
            bus.ex_funct3     = bus.req1_funct3;
            bus.ex_shift_ctrl = bus.req1_shift_ctrl;
            bus.ex_sub_ctrl   = bus.req1_sub_ctrl;
         end else begin
            bus.ex_operation  = bus.req0_operation;
            bus.ex_data_rs1   = bus.req0_rs1;
            bus.ex_data_rs2   = bus.req0_rs2;
            bus.ex_imm        = bus.req0_imm;
            bus.ex_funct3     = bus.req0_funct3;
            bus.ex_shift_ctrl = bus.req0_shift_ctrl;
            bus.ex_sub_ctrl   = bus.req0_sub_ctrl;
         end
      end
   end

   // A transfer overwrites the buffer even while it drains in the same cycle.
   always_comb begin
      last_d      = last_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      cnt0_d      = cnt0_q;
      cnt1_d      = cnt1_q;
      if (xfer_c) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = grant_id_c;
         rsp_data_d  = bus.ex_data_out;
         last_d      = grant_id_c;
         if (grant_id_c) cnt1_d = cnt1_q + CNT_W'(1);
         else            cnt0_d = cnt0_q + CNT_W'(1);
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q      <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= 32'd0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
      end else begin
         last_q      <= last_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.grant_cnt0 = cnt0_q;
   assign bus.grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_ex_arbiter.sv
// Bench for ex_arbiter: directed table, hand sequences for multi-cycle corners,
// then randomized traffic against a transaction-level reference model.
module tb_ex_arbiter;
   localparam int unsigned CNT_W = 16;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_arbiter_if #(.CNT_W(CNT_W)) bus ();
   ex_arbiter #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   int total = 0;
   int bad   = 0;

   // Field bundle {op, rs1, rs2, imm, funct3, shift, sub}
   function automatic logic [31:0] alu(input logic [87:0] f);
      logic [6:0]  op;
      logic [31:0] a, b;
      logic [11:0] imm;
      op = f[87:81]; a = f[80:49]; b = f[48:17]; imm = f[16:5];
      if (op == OP_R)      return f[0] ? a - b : a + b;
      else if (op == OP_I) return a + {{20{imm[11]}}, imm};
      else                 return a ^ b;
   endfunction

   assign bus.ex_data_out = alu({bus.ex_operation, bus.ex_data_rs1, bus.ex_data_rs2,
                                 bus.ex_imm, bus.ex_funct3, bus.ex_shift_ctrl, bus.ex_sub_ctrl});

   function automatic logic [87:0] fields(input logic k);
      if (k) return {bus.req1_operation, bus.req1_rs1, bus.req1_rs2, bus.req1_imm,
                     bus.req1_funct3, bus.req1_shift_ctrl, bus.req1_sub_ctrl};
      return {bus.req0_operation, bus.req0_rs1, bus.req0_rs2, bus.req0_imm,
              bus.req0_funct3, bus.req0_shift_ctrl, bus.req0_sub_ctrl};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic        m_last, m_rv, m_rid;
   logic [31:0] m_rdata;
   int          m_c0, m_c1;
   logic [1:0]  ready_seen;

   task automatic model_reset();
      m_last = 1'b1; m_rv = 1'b0; m_rid = 1'b0; m_rdata = 32'd0; m_c0 = 0; m_c1 = 0;
   endtask

   task automatic set_req(input logic k, input logic [6:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [11:0] imm, input logic sub);
      if (k) begin
         bus.req1_operation = op; bus.req1_rs1 = a; bus.req1_rs2 = b;
         bus.req1_imm = imm; bus.req1_funct3 = 3'd0; bus.req1_shift_ctrl = 1'b0;
         bus.req1_sub_ctrl = sub;
      end else begin
         bus.req0_operation = op; bus.req0_rs1 = a; bus.req0_rs2 = b;
         bus.req0_imm = imm; bus.req0_funct3 = 3'd0; bus.req0_shift_ctrl = 1'b0;
         bus.req0_sub_ctrl = sub;
      end
   endtask

   // One cycle: inputs are set at posedge+1, combinational checks at the
   // falling edge, registered checks at the next posedge+1.
   task automatic tick();
      logic [1:0]  v;
      logic        gv, win, acc;
      logic [31:0] res;
      #4;
      v   = bus.req_valid;
      gv  = (v != 2'b00);
      win = (v == 2'b11) ? ~m_last : v[1];
      acc = gv && (!m_rv || bus.rsp_ready);
      chk("req_ready", bus.req_ready, acc ? (win ? 2'b10 : 2'b01) : 2'b00);
      chk("ex_fields", {bus.ex_operation, bus.ex_data_rs1, bus.ex_data_rs2, bus.ex_imm,
                        bus.ex_funct3, bus.ex_shift_ctrl, bus.ex_sub_ctrl},
          gv ? fields(win) : 88'd0);
      ready_seen = bus.req_ready;
      res = alu(fields(win));
      @(posedge clk);
      if (rst) model_reset();
      else if (acc) begin
         m_rv = 1'b1; m_rid = win; m_rdata = res; m_last = win;
         if (win) m_c1 = (m_c1 + 1) % 65536; else m_c0 = (m_c0 + 1) % 65536;
      end else if (bus.rsp_ready) m_rv = 1'b0;
      #1;
      chk("rsp_valid", bus.rsp_valid, m_rv);
      if (m_rv) begin
         chk("rsp_id", bus.rsp_id, m_rid);
         chk("rsp_data", bus.rsp_data, m_rdata);
      end
      chk("grant_cnt0", bus.grant_cnt0, CNT_W'(m_c0));
      chk("grant_cnt1", bus.grant_cnt1, CNT_W'(m_c1));
   endtask

   typedef struct {
      logic [1:0]  v;
      logic        rr;
      logic [31:0] a0, b0, a1, b1;
      logic [1:0]  exp_ready;
      logic        exp_rv;
      logic        exp_id;
      logic [31:0] exp_data;
      logic [15:0] exp_c0, exp_c1;
   } vec_t;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{2'b11, 1'b1,   1,  2, 10, 20, 2'b01, 1'b1, 1'b0,  3, 1, 0};
      tbl[1]  = '{2'b11, 1'b1,   3,  4, 10, 20, 2'b10, 1'b1, 1'b1, 30, 1, 1};
      tbl[2]  = '{2'b11, 1'b1,   5,  5, 10, 20, 2'b01, 1'b1, 1'b0, 10, 2, 1};
      tbl[3]  = '{2'b11, 1'b1,   5,  5,  7,  8, 2'b10, 1'b1, 1'b1, 15, 2, 2};
      tbl[4]  = '{2'b11, 1'b0,  40, 40, 50, 50, 2'b00, 1'b1, 1'b1, 15, 2, 2};
      tbl[5]  = '{2'b11, 1'b0,  41, 41, 51, 51, 2'b00, 1'b1, 1'b1, 15, 2, 2};
      tbl[6]  = '{2'b11, 1'b0,  42, 42, 52, 52, 2'b00, 1'b1, 1'b1, 15, 2, 2};
      tbl[7]  = '{2'b11, 1'b1, 100,  1, 60, 60, 2'b01, 1'b1, 1'b0, 101, 3, 2};
      tbl[8]  = '{2'b00, 1'b1,   0,  0,  0,  0, 2'b00, 1'b0, 1'b0,  0, 3, 2};
      tbl[9]  = '{2'b10, 1'b0,   0,  0,  9,  9, 2'b10, 1'b1, 1'b1, 18, 3, 3};
      tbl[10] = '{2'b01, 1'b0,   6,  6,  0,  0, 2'b00, 1'b1, 1'b1, 18, 3, 3};
      tbl[11] = '{2'b01, 1'b1,   2,  2,  0,  0, 2'b01, 1'b1, 1'b0,  4, 4, 3};

      rst = 1'b1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b0;
      set_req(1'b0, OP_R, 0, 0, 0, 1'b0);
      set_req(1'b1, OP_R, 0, 0, 0, 1'b0);
      @(posedge clk); #1;
      model_reset();
      tick();
      chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
      chk("reset_rsp_id", bus.rsp_id, 1'b0);
      chk("reset_rsp_data", bus.rsp_data, 32'd0);
      chk("reset_cnt0", bus.grant_cnt0, 16'd0);
      rst = 1'b0;

      // Contention, backpressure, release and mixed singles from reset.
      for (int i = 0; i < 12; i++) begin
         bus.req_valid = tbl[i].v;
         bus.rsp_ready = tbl[i].rr;
         set_req(1'b0, OP_R, tbl[i].a0, tbl[i].b0, 12'd0, 1'b0);
         set_req(1'b1, OP_R, tbl[i].a1, tbl[i].b1, 12'd0, 1'b0);
         tick();
         chk($sformatf("tbl%0d_ready", i), ready_seen, tbl[i].exp_ready);
         chk($sformatf("tbl%0d_rv", i), bus.rsp_valid, tbl[i].exp_rv);
         if (tbl[i].exp_rv) begin
            chk($sformatf("tbl%0d_id", i), bus.rsp_id, tbl[i].exp_id);
            chk($sformatf("tbl%0d_data", i), bus.rsp_data, tbl[i].exp_data);
         end
         chk($sformatf("tbl%0d_c0", i), bus.grant_cnt0, tbl[i].exp_c0);
         chk($sformatf("tbl%0d_c1", i), bus.grant_cnt1, tbl[i].exp_c1);
      end

      // Single ADD, then ADDI and SUB from requester 1.
      rst = 1'b1; bus.req_valid = 2'b00; tick(); rst = 1'b0;
      bus.req_valid = 2'b01; bus.rsp_ready = 1'b1;
      set_req(1'b0, OP_R, 5, 7, 12'd0, 1'b0);
      tick();
      chk("single_rv", bus.rsp_valid, 1'b1);
      chk("single_id", bus.rsp_id, 1'b0);
      chk("single_data", bus.rsp_data, 32'd12);
      chk("single_cnt0", bus.grant_cnt0, 16'd1);
      bus.req_valid = 2'b10;
      set_req(1'b1, OP_I, 1, 0, 12'hFFF, 1'b0);
      tick();
      chk("addi_id", bus.rsp_id, 1'b1);
      chk("addi_data", bus.rsp_data, 32'd0);
      set_req(1'b1, OP_R, 3, 5, 12'd0, 1'b1);
      tick();
      chk("sub_data", bus.rsp_data, 32'hFFFF_FFFE);

      // Back-to-back from requester 0.
      bus.req_valid = 2'b01;
      for (int i = 1; i <= 5; i++) begin
         set_req(1'b0, OP_R, 32'(i), 32'(i * 10), 12'd0, 1'b0);
         tick();
         chk($sformatf("b2b%0d_rv", i), bus.rsp_valid, 1'b1);
         chk($sformatf("b2b%0d_data", i), bus.rsp_data, 32'(i * 11));
      end
      chk("b2b_cnt0", bus.grant_cnt0, 16'd6);

      // Reset while a response is stalled.
      bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
      tick();
      chk("stall_rv", bus.rsp_valid, 1'b1);
      rst = 1'b1;
      tick();
      chk("midrst_rv", bus.rsp_valid, 1'b0);
      chk("midrst_cnt0", bus.grant_cnt0, 16'd0);
      chk("midrst_cnt1", bus.grant_cnt1, 16'd0);
      rst = 1'b0;
      bus.req_valid = 2'b11; bus.rsp_ready = 1'b1;
      tick();
      chk("midrst_first_grant", ready_seen, 2'b01);
      chk("midrst_first_id", bus.rsp_id, 1'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         bus.req_valid = 2'($urandom_range(0, 3));
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 2; k++) begin
            logic [6:0] op;
            case ($urandom_range(0, 2))
               0:       op = OP_R;
               1:       op = OP_I;
               default: op = 7'($urandom);
            endcase
            set_req(k[0], op, $urandom, $urandom, 12'($urandom), 1'($urandom));
            if (k == 0) bus.req0_funct3 = 3'($urandom);
            else        bus.req1_shift_ctrl = 1'($urandom);
         end
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
